// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard port: register offsets, STATUS bit
// positions, receive-frame state encoding and the frame parity check.
package ps2_pkg;

  localparam logic [3:0] DATA_OFS   = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_PERR      = 3;
  localparam int unsigned ST_CNT_LSB   = 4;
  localparam int unsigned ST_CNT_W     = 4;
  localparam int unsigned ST_IRQ_MASK  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // PS/2 frames use odd parity across the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronisers, falling-edge strobe,
// start/data/parity/stop state machine and partial-frame timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_parity_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic            clk_prev;
  logic            sample_c;
  logic            bit_c;
  rx_state_e       state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;

  // Synchronisers reset to the idle-high line level so release never looks like an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], i_ps2_clk};
      data_sync <= {data_sync[0], i_ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign sample_c = clk_prev & ~clk_sync[1];
  assign bit_c    = data_sync[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 8'd0;
      par_bit      <= 1'b0;
      to_cnt       <= '0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_parity_err <= 1'b0;
      if (sample_c) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!bit_c) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift   <= {bit_c, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= bit_c;
            state   <= STOP;
          end
          STOP: begin
            if (bit_c && odd_parity_ok(shift, par_bit)) begin
              o_byte       <= shift;
              o_byte_valid <= 1'b1;
            end else begin
              o_parity_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A stalled device abandons the frame silently.
        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state  <= IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_port.sv
// Memory-mapped PS/2 keyboard port: scan-code FIFO plus DATA/STATUS registers.
// Optional PS2_IRQ_EN adds o_irq and the STATUS IRQ_MASK bit.
module ps2_keyboard_port
  import ps2_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_bus_data,
  input  logic [31:0] i_bus_address,
  input  logic        i_bus_DV,
  input  logic [2:0]  i_bhw,
  input  logic        i_write_notread,
  output logic [31:0] o_bus_data,
  output logic        o_bus_DV,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_data
`ifdef PS2_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             rx_perr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             perr;
  logic             not_empty_c;
  logic             full_c;
  logic             hit_c;
  logic [3:0]       ofs_c;
  logic             pop_c;
  logic             push_ok_c;
  logic             ovf_set_c;
  logic             wr_status_c;
  logic [31:0]      status_c;
  logic [31:0]      rdata_c;
  logic             unused_c;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ps2_clk    (i_ps2_clk),
    .i_ps2_data   (i_ps2_data),
    .o_byte       (rx_byte),
    .o_byte_valid (rx_valid),
    .o_parity_err (rx_perr)
  );

  assign not_empty_c = (count != '0);
  assign full_c      = (count == CNT_W'(FIFO_DEPTH));
  assign hit_c       = i_bus_DV && (i_bus_address[31:4] == BASE_ADDR[31:4]);
  assign ofs_c       = {i_bus_address[3:2], 2'b00};
  assign pop_c       = hit_c && !i_write_notread && (ofs_c == DATA_OFS) && not_empty_c;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_ok_c   = rx_valid && (!full_c || pop_c);
  assign ovf_set_c   = rx_valid && full_c && !pop_c;
  assign wr_status_c = hit_c && i_write_notread && (ofs_c == STATUS_OFS);

`ifdef PS2_IRQ_EN
  logic irq_mask;
  assign unused_c = ^{i_bhw, i_bus_data[31:9], i_bus_data[7:4], i_bus_data[1:0],
                      i_bus_address[1:0]};
`else
  assign unused_c = ^{i_bhw, i_bus_data[31:4], i_bus_data[1:0], i_bus_address[1:0]};
`endif

  always_comb begin
    status_c = '0;
    status_c[ST_NOT_EMPTY] = not_empty_c;
    status_c[ST_FULL]      = full_c;
    status_c[ST_OVF]       = ovf;
    status_c[ST_PERR]      = perr;
    status_c[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(count);
`ifdef PS2_IRQ_EN
    status_c[ST_IRQ_MASK]  = irq_mask;
`endif
  end

  always_comb begin
    rdata_c = '0;
    if (ofs_c == DATA_OFS) begin
      if (not_empty_c) rdata_c = {24'd0, mem[rd_ptr]};
    end else if (ofs_c == STATUS_OFS) begin
      rdata_c = status_c;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok_c) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      perr       <= 1'b0;
      o_bus_DV   <= 1'b0;
      o_bus_data <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok_c && !pop_c)      count <= count + CNT_W'(1);
      else if (pop_c && !push_ok_c) count <= count - CNT_W'(1);
      // Set events take priority over a simultaneous write-one-to-clear.
      if (ovf_set_c)                          ovf <= 1'b1;
      else if (wr_status_c && i_bus_data[ST_OVF])  ovf <= 1'b0;
      if (rx_perr)                            perr <= 1'b1;
      else if (wr_status_c && i_bus_data[ST_PERR]) perr <= 1'b0;
      o_bus_DV   <= hit_c;
      o_bus_data <= (hit_c && !i_write_notread) ? rdata_c : '0;
    end
  end

`ifdef PS2_IRQ_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_mask <= 1'b1;
      o_irq    <= 1'b0;
    end else begin
      if (wr_status_c) irq_mask <= i_bus_data[ST_IRQ_MASK];
      o_irq <= !irq_mask && (not_empty_c || ovf || perr);
    end
  end
`endif

endmodule

// File: tb/tb_ps2_keyboard_port.sv
// Bench for ps2_keyboard_port: directed and random PS/2 frames checked against a queue model.
module tb_ps2_keyboard_port;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 400;
  localparam int unsigned HALF  = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_bus_data = '0;
  logic [31:0] i_bus_address = '0;
  logic        i_bus_DV = 1'b0;
  logic [2:0]  i_bhw = 3'd0;
  logic        i_write_notread = 1'b0;
  logic [31:0] o_bus_data;
  logic        o_bus_DV;
  logic        i_ps2_clk = 1'b1;
  logic        i_ps2_data = 1'b1;

  always #5 i_clk = ~i_clk;

  ps2_keyboard_port #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bus_data(i_bus_data), .i_bus_address(i_bus_address),
    .i_bus_DV(i_bus_DV), .i_bhw(i_bhw), .i_write_notread(i_write_notread),
    .o_bus_data(o_bus_data), .o_bus_DV(o_bus_DV),
    .i_ps2_clk(i_ps2_clk), .i_ps2_data(i_ps2_data)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];
  logic       m_ovf  = 1'b0;
  logic       m_perr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = model_q.size();
    return {24'd0, 4'(n), m_perr, m_ovf, 1'(n == int'(DEPTH)), 1'(n != 0)};
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic good);
    if (!good) m_perr = 1'b1;
    else if (model_q.size() < int'(DEPTH)) model_q.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  task automatic ps2_bit(input logic b);
    i_ps2_data = b;
    repeat (HALF) @(negedge i_clk);
    i_ps2_clk = 1'b0;
    repeat (HALF) @(negedge i_clk);
    i_ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(~bad_stop);
    i_ps2_data = 1'b1;
    repeat (HALF) @(negedge i_clk);
    model_frame(b, !bad_par && !bad_stop);
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          output logic dv, output logic [31:0] rdata);
    @(negedge i_clk);
    i_bus_address   = addr;
    i_write_notread = wr;
    i_bus_data      = wdata;
    i_bus_DV        = 1'b1;
    @(negedge i_clk);
    dv       = o_bus_DV;
    rdata    = o_bus_data;
    i_bus_DV = 1'b0;
  endtask

  task automatic read_status(input string tag);
    logic dv;
    logic [31:0] d;
    bus_xfer(BASE + 32'h4, 1'b0, '0, dv, d);
    check({tag, " dv"}, {31'd0, dv}, 32'd1);
    check(tag, d, exp_status());
  endtask

  task automatic read_data(input string tag);
    logic dv;
    logic [31:0] d;
    logic [31:0] exp;
    exp = (model_q.size() > 0) ? {24'd0, model_q.pop_front()} : 32'd0;
    bus_xfer(BASE, 1'b0, '0, dv, d);
    check({tag, " dv"}, {31'd0, dv}, 32'd1);
    check(tag, d, exp);
  endtask

  task automatic write_status(input string tag, input logic [31:0] w);
    logic dv;
    logic [31:0] d;
    bus_xfer(BASE + 32'h4, 1'b1, w, dv, d);
    check({tag, " dv"}, {31'd0, dv}, 32'd1);
    check({tag, " wdata"}, d, 32'd0);
    if (w[2]) m_ovf = 1'b0;
    if (w[3]) m_perr = 1'b0;
  endtask

  initial begin
    logic dv;
    logic [31:0] d;
    logic [31:0] exp;

    // reset state
    repeat (3) @(negedge i_clk);
    check("rst dv", {31'd0, o_bus_DV}, 32'd0);
    check("rst data", o_bus_data, 32'd0);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
    read_status("idle status");

    // single good frame
    send_frame(8'h1C, 1'b0, 1'b0);
    read_status("1c status");
    read_data("1c data");
    read_status("1c status after");
    @(negedge i_clk);
    check("dv one cycle", {31'd0, o_bus_DV}, 32'd0);

    // parity error then W1C
    send_frame(8'h1C, 1'b1, 1'b0);
    read_status("perr status");
    write_status("perr clear", 32'h0000_0008);
    read_status("perr cleared");

    // overflow with nine frames
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    read_status("ovf status");
    for (int i = 0; i < 9; i++) read_data("ovf drain");
    write_status("ovf clear", 32'h0000_0004);
    read_status("ovf cleared");

    // timeout on a partial frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (TMO + 10) @(negedge i_clk);
    read_status("timeout status");
    send_frame(8'hF0, 1'b0, 1'b0);
    read_status("after timeout status");
    read_data("after timeout data");

    // full FIFO: push lands together with a DATA pop
    for (int i = 0; i < 8; i++) send_frame(8'h30 + 8'(i), 1'b0, 1'b0);
    read_status("full status");
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(i[0] ? 1'b0 : 1'b1);
    ps2_bit(1'b1);
    i_ps2_data = 1'b1;
    repeat (HALF) @(negedge i_clk);
    i_ps2_clk = 1'b0;
    repeat (3) @(negedge i_clk);
    i_bus_address = BASE;
    i_write_notread = 1'b0;
    i_bus_DV = 1'b1;
    @(negedge i_clk);
    i_bus_DV = 1'b0;
    exp = {24'd0, model_q.pop_front()};
    check("coinc dv", {31'd0, o_bus_DV}, 32'd1);
    check("coinc data", o_bus_data, exp);
    model_frame(8'h55, 1'b1);
    repeat (HALF - 4) @(negedge i_clk);
    i_ps2_clk = 1'b1;
    repeat (HALF) @(negedge i_clk);
    read_status("coinc status");
    for (int i = 0; i < 8; i++) read_data("coinc drain");
    read_status("coinc empty");

    // random frames and bus operations
    for (int it = 0; it < 24; it++) begin
      logic [7:0] b;
      int kind;
      b = 8'($urandom);
      kind = int'($urandom_range(0, 7));
      send_frame(b, kind == 0, kind == 1);
      case ($urandom_range(0, 3))
        0: read_status("rnd status");
        1: read_data("rnd data");
        2: write_status("rnd w1c", $urandom);
        default: begin
          bus_xfer(BASE + 32'h8, 1'b0, '0, dv, d);
          check("rnd rsvd dv", {31'd0, dv}, 32'd1);
          check("rnd rsvd data", d, 32'd0);
        end
      endcase
    end
    read_status("rnd final status");
    while (model_q.size() > 0) read_data("rnd drain");
    read_data("rnd empty read");
    write_status("rnd clear", 32'h0000_000C);
    read_status("rnd clean");

    // reset mid-frame and mid-fill
    send_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    i_ps2_clk = 1'b0;
    i_bus_address = BASE + 32'h4;
    i_write_notread = 1'b0;
    i_bus_DV = 1'b1;
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("midrst dv", {31'd0, o_bus_DV}, 32'd0);
    check("midrst data", o_bus_data, 32'd0);
    i_bus_DV = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    m_perr = 1'b0;
    i_ps2_clk = 1'b1;
    i_ps2_data = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    read_status("after rst status");
    bus_xfer(BASE + 32'h20, 1'b0, '0, dv, d);
    check("outside dv", {31'd0, dv}, 32'd0);
    @(negedge i_clk);
    check("outside dv late", {31'd0, o_bus_DV}, 32'd0);
    send_frame(8'hE7, 1'b0, 1'b0);
    read_status("post rst frame status");
    read_data("post rst frame data");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
